multicycle_control_fsm: RTL and testbench

- Control unit for the multicycle RV32I datapath. It sequences each instruction through fetch, decode, execute, memory and writeback states.
- It is the producer side of the ALU interface: it drives `alu_control` (3-bit) and the operand-select muxes, and consumes `zero_flag` and `negative_flag` for branch resolution.
- Memory accesses use a `mem_ready` handshake, so the FSM stalls on slow memory.

---
 rtl/multicycle_control_fsm.sv | 215 +++++++++++++++++++++
 tb/tb_multicycle_control_fsm.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_control_fsm.sv
// Multicycle RV32I control FSM: sequences fetch/decode/execute/memory/writeback and drives ALU/mux selects.
// Optional macro ILLEGAL_TRAP_EN: illegal instructions park the FSM in a sticky TRAP state.
//
// state    | meaning
// FETCH    | read instruction at PC, PC <= PC+4 when mem_ready
// DECODE   | ALUOut <= old PC + imm (branch target), dispatch on opcode
// MEMADR   | ALUOut <= rs1 + imm
// MEMREAD  | read data at ALUOut until mem_ready
// MEMWB    | rd <= data register
// MEMWRITE | store at ALUOut until mem_ready
// EXECUTER | ALUOut <= rs1 op rs2
// EXECUTEI | ALUOut <= rs1 op imm
// ALUWB    | rd <= ALUOut
// JAL      | PC <= branch target, ALUOut <= old PC + 4
// BRANCH   | compare rs1 - rs2, PC <= target if taken
// TRAP     | illegal instruction seen, waits for reset (ILLEGAL_TRAP_EN only)
module multicycle_control_fsm #(
    parameter int STATE_W = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic       funct7_5,
    input  logic       zero_flag,
    input  logic       negative_flag,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic       adr_src,
    output logic       mem_write,
    output logic       ir_write,
    output logic       reg_write,
    output logic [1:0] result_src,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] imm_src,
    output logic [2:0] alu_control,
    output logic       illegal_instr
);
    localparam logic [STATE_W-1:0] S_FETCH    = STATE_W'(0);
    localparam logic [STATE_W-1:0] S_DECODE   = STATE_W'(1);
    localparam logic [STATE_W-1:0] S_MEMADR   = STATE_W'(2);
    localparam logic [STATE_W-1:0] S_MEMREAD  = STATE_W'(3);
    localparam logic [STATE_W-1:0] S_MEMWB    = STATE_W'(4);
    localparam logic [STATE_W-1:0] S_MEMWRITE = STATE_W'(5);
    localparam logic [STATE_W-1:0] S_EXECR    = STATE_W'(6);
    localparam logic [STATE_W-1:0] S_EXECI    = STATE_W'(7);
    localparam logic [STATE_W-1:0] S_ALUWB    = STATE_W'(8);
    localparam logic [STATE_W-1:0] S_JAL      = STATE_W'(9);
    localparam logic [STATE_W-1:0] S_BRANCH   = STATE_W'(10);
`ifdef ILLEGAL_TRAP_EN
    localparam logic [STATE_W-1:0] S_TRAP     = STATE_W'(11);
    localparam logic [STATE_W-1:0] S_ILL      = S_TRAP;
`else
    localparam logic [STATE_W-1:0] S_ILL      = S_FETCH;
`endif

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_JAL = 7'b1101111;
    localparam logic [6:0] OP_BR  = 7'b1100011;

    localparam logic [2:0] ALU_ZERO = 3'b000;
    localparam logic [2:0] ALU_AND  = 3'b001;
    localparam logic [2:0] ALU_XOR  = 3'b010;
    localparam logic [2:0] ALU_SUB  = 3'b011;
    localparam logic [2:0] ALU_ADD  = 3'b100;
    localparam logic [2:0] ALU_OR   = 3'b101;
    localparam logic [2:0] ALU_LSL  = 3'b110;
    localparam logic [2:0] ALU_LSR  = 3'b111;

    logic [STATE_W-1:0] state_q, state_d;
    logic [2:0]         alu_fn;
    logic               fn_legal;
    logic               pc_write_c, mem_write_c, ir_write_c, reg_write_c;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_FETCH;
        else        state_q <= state_d;
    end

    // Funct decode shared by EXECUTER and EXECUTEI; SUB only exists for R-type.
    always_comb begin
        fn_legal = 1'b1;
        alu_fn   = ALU_ZERO;
        case (funct3)
            3'b000:  alu_fn = (opcode == OP_R && funct7_5) ? ALU_SUB : ALU_ADD;
            3'b001:  alu_fn = ALU_LSL;
            3'b100:  alu_fn = ALU_XOR;
            3'b101:  alu_fn = ALU_LSR;
            3'b110:  alu_fn = ALU_OR;
            3'b111:  alu_fn = ALU_AND;
            default: fn_legal = 1'b0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH:    if (mem_ready) state_d = S_DECODE;
            S_DECODE: begin
                case (opcode)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_R:         state_d = S_EXECR;
                    OP_I:         state_d = S_EXECI;
                    OP_JAL:       state_d = S_JAL;
                    OP_BR:        state_d = S_BRANCH;
                    default:      state_d = S_ILL;
                endcase
            end
            S_MEMADR:   state_d = (opcode == OP_LW) ? S_MEMREAD : S_MEMWRITE;
            S_MEMREAD:  if (mem_ready) state_d = S_MEMWB;
            S_MEMWRITE: if (mem_ready) state_d = S_FETCH;
            S_EXECR,
            S_EXECI:    state_d = fn_legal ? S_ALUWB : S_ILL;
            S_JAL:      state_d = S_ALUWB;
`ifdef ILLEGAL_TRAP_EN
            S_TRAP:     state_d = S_TRAP;
`endif
            default:    state_d = S_FETCH;
        endcase
    end

    always_comb begin
        pc_write_c  = 1'b0;
        adr_src     = 1'b0;
        mem_write_c = 1'b0;
        ir_write_c  = 1'b0;
        reg_write_c = 1'b0;
        result_src  = 2'b00;
        alu_src_a   = 2'b00;
        alu_src_b   = 2'b00;
        alu_control = ALU_ZERO;
        case (state_q)
            S_FETCH: begin
                alu_src_b   = 2'b10;
                alu_control = ALU_ADD;
                result_src  = 2'b10;
                ir_write_c  = mem_ready;
                pc_write_c  = mem_ready;
            end
            S_DECODE: begin
                alu_src_a   = 2'b01;
                alu_src_b   = 2'b01;
                alu_control = ALU_ADD;
            end
            S_MEMADR: begin
                alu_src_a   = 2'b10;
                alu_src_b   = 2'b01;
                alu_control = ALU_ADD;
            end
            S_MEMREAD:  adr_src = 1'b1;
            S_MEMWB: begin
                result_src  = 2'b01;
                reg_write_c = 1'b1;
            end
            S_MEMWRITE: begin
                adr_src     = 1'b1;
                mem_write_c = 1'b1;
            end
            S_EXECR: begin
                alu_src_a   = 2'b10;
                alu_control = alu_fn;
            end
            S_EXECI: begin
                alu_src_a   = 2'b10;
                alu_src_b   = 2'b01;
                alu_control = alu_fn;
            end
            S_ALUWB:    reg_write_c = 1'b1;
            S_JAL: begin
                alu_src_a   = 2'b01;
                alu_src_b   = 2'b10;
                alu_control = ALU_ADD;
                pc_write_c  = 1'b1;
            end
            S_BRANCH: begin
                alu_src_a   = 2'b10;
                alu_control = ALU_SUB;
                case (funct3)
                    3'b000:  pc_write_c = zero_flag;
                    3'b001:  pc_write_c = !zero_flag;
                    3'b100:  pc_write_c = negative_flag;
                    3'b101:  pc_write_c = !negative_flag;
                    default: pc_write_c = 1'b0;
                endcase
            end
            default: ;
        endcase
    end

    always_comb begin
        case (opcode)
            OP_LW, OP_I: imm_src = 2'b00;
            OP_SW:       imm_src = 2'b01;
            OP_BR:       imm_src = 2'b10;
            OP_JAL:      imm_src = 2'b11;
            default:     imm_src = 2'b00;
        endcase
    end

    // State is already FETCH during reset; strobes are also gated so a high
    // mem_ready cannot leak ir_write/pc_write while rst_n is low.
    assign pc_write  = pc_write_c  & rst_n;
    assign mem_write = mem_write_c & rst_n;
    assign ir_write  = ir_write_c  & rst_n;
    assign reg_write = reg_write_c & rst_n;
`ifdef ILLEGAL_TRAP_EN
    assign illegal_instr = (state_q == S_TRAP) & rst_n;
`else
    assign illegal_instr = 1'b0;
`endif
endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Scoreboard bench for multicycle_control_fsm: per-instruction step sequences are queued and checked at negedge.
module tb_multicycle_control_fsm;
    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_JAL = 7'b1101111;
    localparam logic [6:0] OP_BR  = 7'b1100011;

    typedef struct packed {
        logic       pc_write;
        logic       adr_src;
        logic       mem_write;
        logic       ir_write;
        logic       reg_write;
        logic [1:0] result_src;
        logic [1:0] alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] imm_src;
        logic [2:0] alu_control;
        logic       illegal_instr;
    } outs_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [6:0] opcode = 7'd0;
    logic [2:0] funct3 = 3'd0;
    logic       funct7_5 = 1'b0;
    logic       zero_flag = 1'b0;
    logic       negative_flag = 1'b0;
    logic       mem_ready = 1'b0;
    logic       pc_write, adr_src, mem_write, ir_write, reg_write, illegal_instr;
    logic [1:0] result_src, alu_src_a, alu_src_b, imm_src;
    logic [2:0] alu_control;
    outs_t      act;

    multicycle_control_fsm #(.STATE_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct3(funct3), .funct7_5(funct7_5),
        .zero_flag(zero_flag), .negative_flag(negative_flag), .mem_ready(mem_ready),
        .pc_write(pc_write), .adr_src(adr_src), .mem_write(mem_write), .ir_write(ir_write),
        .reg_write(reg_write), .result_src(result_src), .alu_src_a(alu_src_a),
        .alu_src_b(alu_src_b), .imm_src(imm_src), .alu_control(alu_control),
        .illegal_instr(illegal_instr)
    );

    assign act = {pc_write, adr_src, mem_write, ir_write, reg_write, result_src,
                  alu_src_a, alu_src_b, imm_src, alu_control, illegal_instr};

    always #5 clk = ~clk;

    int    n_chk = 0;
    int    n_pass = 0;
    outs_t exp_q[$];
    string nm_q[$];
    logic [6:0] cur_op = 7'd0;

    task automatic chk(string nm, outs_t got, outs_t exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got=%b expected=%b", nm, got, exp);
    endtask

    always @(negedge clk) begin
        outs_t e;
        string nm;
        if (exp_q.size() != 0) begin
            e  = exp_q.pop_front();
            nm = nm_q.pop_front();
            chk(nm, act, e);
        end
    end

    function automatic logic rb();
        return 1'($urandom_range(0, 1));
    endfunction

    // ---------------- reference model ----------------
    function automatic logic [1:0] imm_of(logic [6:0] op);
        if (op == OP_SW) return 2'b01;
        if (op == OP_BR) return 2'b10;
        if (op == OP_JAL) return 2'b11;
        return 2'b00;
    endfunction

    function automatic outs_t base();
        outs_t e = '0;
        e.imm_src = imm_of(cur_op);
        return e;
    endfunction

    function automatic logic [2:0] fn_op(logic [2:0] f3, logic rtype, logic f75);
        case (f3)
            3'd0:    return (rtype && f75) ? 3'b011 : 3'b100;
            3'd1:    return 3'b110;
            3'd4:    return 3'b010;
            3'd5:    return 3'b111;
            3'd6:    return 3'b101;
            3'd7:    return 3'b001;
            default: return 3'b000;
        endcase
    endfunction

    function automatic logic br_taken(logic [2:0] f3, logic zf, logic nf);
        case (f3)
            3'd0:    return zf;
            3'd1:    return !zf;
            3'd4:    return nf;
            3'd5:    return !nf;
            default: return 1'b0;
        endcase
    endfunction

    function automatic outs_t e_fetch(logic rdy);
        outs_t e = base();
        e.alu_src_b = 2'b10; e.alu_control = 3'b100; e.result_src = 2'b10;
        e.ir_write = rdy; e.pc_write = rdy;
        return e;
    endfunction

    function automatic outs_t e_addr(logic [1:0] a, logic [1:0] b, logic [2:0] op);
        outs_t e = base();
        e.alu_src_a = a; e.alu_src_b = b; e.alu_control = op;
        return e;
    endfunction

    function automatic outs_t e_mem(logic wr);
        outs_t e = base();
        e.adr_src = 1'b1; e.mem_write = wr;
        return e;
    endfunction

    function automatic outs_t e_wb(logic [1:0] rs);
        outs_t e = base();
        e.result_src = rs; e.reg_write = 1'b1;
        return e;
    endfunction

    // ---------------- stimulus ----------------
    task automatic step(string nm, logic mr, logic zf, logic nf, outs_t e);
        mem_ready = mr; zero_flag = zf; negative_flag = nf;
        exp_q.push_back(e);
        nm_q.push_back(nm);
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset(string nm);
        rst_n = 1'b0;
        mem_ready = 1'b1;
        #1 chk({nm, "_async"}, act, e_fetch(1'b0));
        @(posedge clk);
        #1 chk({nm, "_hold"}, act, e_fetch(1'b0));
        rst_n = 1'b1;
    endtask

    task automatic illegal_tail(string nm);
`ifdef ILLEGAL_TRAP_EN
        outs_t e = base();
        e.illegal_instr = 1'b1;
        repeat (10) step({nm, "_trap"}, rb(), rb(), rb(), e);
        pulse_reset({nm, "_trap_exit"});
`endif
    endtask

    task automatic fetch_decode(int fstall);
        repeat (fstall) step("fetch_stall", 1'b0, rb(), rb(), e_fetch(1'b0));
        step("fetch", 1'b1, rb(), rb(), e_fetch(1'b1));
        step("decode", rb(), rb(), rb(), e_addr(2'b01, 2'b01, 3'b100));
    endtask

    task automatic run_instr(logic [6:0] op, logic [2:0] f3, logic f75,
                             logic zf, logic nf, int fstall, int mstall);
        logic legal_fn;
        cur_op = op; opcode = op; funct3 = f3; funct7_5 = f75;
        legal_fn = (f3 != 3'd2) && (f3 != 3'd3);
        fetch_decode(fstall);
        case (op)
            OP_LW: begin
                step("memadr_lw", rb(), rb(), rb(), e_addr(2'b10, 2'b01, 3'b100));
                repeat (mstall) step("memread_stall", 1'b0, rb(), rb(), e_mem(1'b0));
                step("memread", 1'b1, rb(), rb(), e_mem(1'b0));
                step("memwb", rb(), rb(), rb(), e_wb(2'b01));
            end
            OP_SW: begin
                step("memadr_sw", rb(), rb(), rb(), e_addr(2'b10, 2'b01, 3'b100));
                repeat (mstall) step("memwrite_stall", 1'b0, rb(), rb(), e_mem(1'b1));
                step("memwrite", 1'b1, rb(), rb(), e_mem(1'b1));
            end
            OP_R, OP_I: begin
                step(op == OP_R ? "execr" : "execi", rb(), rb(), rb(),
                     e_addr(2'b10, op == OP_R ? 2'b00 : 2'b01, fn_op(f3, op == OP_R, f75)));
                if (legal_fn) step("aluwb", rb(), rb(), rb(), e_wb(2'b00));
                else illegal_tail("bad_funct3");
            end
            OP_JAL: begin
                outs_t e = e_addr(2'b01, 2'b10, 3'b100);
                e.pc_write = 1'b1;
                step("jal", rb(), rb(), rb(), e);
                step("jal_aluwb", rb(), rb(), rb(), e_wb(2'b00));
            end
            OP_BR: begin
                outs_t e = e_addr(2'b10, 2'b00, 3'b011);
                e.pc_write = br_taken(f3, zf, nf);
                step("branch", rb(), zf, nf, e);
            end
            default: illegal_tail("bad_opcode");
        endcase
    endtask

    initial begin
        logic [6:0] ill_ops [4];
        logic [6:0] leg_ops [6];
        logic [6:0] op;
        outs_t e;
        ill_ops = '{7'b0000000, 7'b1111111, 7'b0110111, 7'b1100111};
        leg_ops = '{OP_LW, OP_SW, OP_R, OP_I, OP_JAL, OP_BR};

        mem_ready = 1'b1;
        #1 chk("reset_initial", act, e_fetch(1'b0));
        @(posedge clk);
        @(posedge clk);
        #1 chk("reset_initial_hold", act, e_fetch(1'b0));
        rst_n = 1'b1;

        run_instr(OP_R,   3'd0, 1'b0, 1'b0, 1'b0, 0, 0);   // add
        run_instr(OP_R,   3'd0, 1'b1, 1'b0, 1'b0, 0, 0);   // sub
        run_instr(OP_I,   3'd0, 1'b1, 1'b0, 1'b0, 0, 0);   // addi ignores funct7_5
        run_instr(OP_LW,  3'd2, 1'b0, 1'b0, 1'b0, 0, 3);
        run_instr(OP_SW,  3'd2, 1'b0, 1'b0, 1'b0, 2, 2);
        run_instr(OP_BR,  3'd0, 1'b0, 1'b1, 1'b0, 0, 0);   // beq taken
        run_instr(OP_BR,  3'd1, 1'b0, 1'b1, 1'b0, 0, 0);   // bne not taken
        run_instr(OP_BR,  3'd4, 1'b0, 1'b0, 1'b1, 0, 0);   // blt taken
        run_instr(OP_BR,  3'd2, 1'b0, 1'b1, 1'b1, 0, 0);   // unused funct3
        run_instr(OP_JAL, 3'd0, 1'b0, 1'b0, 1'b0, 1, 0);
        run_instr(7'b0000000, 3'd0, 1'b0, 1'b0, 1'b0, 0, 0);
        run_instr(OP_R,   3'd2, 1'b0, 1'b0, 1'b0, 0, 0);   // slt
        run_instr(OP_I,   3'd3, 1'b0, 1'b0, 1'b0, 0, 0);   // sltiu

        // Reset asserted in the middle of a stalled store.
        cur_op = OP_SW; opcode = OP_SW; funct3 = 3'd2; funct7_5 = 1'b0;
        fetch_decode(0);
        step("memadr_sw", rb(), rb(), rb(), e_addr(2'b10, 2'b01, 3'b100));
        mem_ready = 1'b0;
        #1 chk("memwrite_pre_reset", act, e_mem(1'b1));
        pulse_reset("reset_in_memwrite");
        run_instr(OP_R, 3'd7, 1'b0, 1'b0, 1'b0, 0, 0);

        for (int i = 0; i < 150; i++) begin
            if ($urandom_range(0, 9) == 0) op = ill_ops[$urandom_range(0, 3)];
            else op = leg_ops[$urandom_range(0, 5)];
            run_instr(op, 3'($urandom_range(0, 7)), rb(), rb(), rb(),
                      $urandom_range(0, 2), $urandom_range(0, 3));
        end

        @(negedge clk);
        #1;
        n_chk++;
        if (exp_q.size() == 0) n_pass++;
        else $display("FAIL scoreboard_drain: got=%0d pending expected=0", exp_q.size());
        e = base();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
